pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL provide parameter XLEN, default 32: PC width in bits (16..64).
REQ-002 SHALL provide parameter RESET_VEC, default 0: PC value on reset.
REQ-003 SHALL provide parameter STEP, default 4: sequential increment, power of two.
REQ-004 SHALL provide parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-005 SHALL provide port CLK, input, 1: single clock, rising edge.
REQ-006 SHALL provide port RST_N, input, 1: asynchronous active-low reset.
REQ-007 SHALL provide port PC_EN, input, 1: advance enable; 0 = stall.
REQ-008 SHALL provide port BR_TAKEN, input, 1: conditional branch taken.
REQ-009 SHALL provide port BR_TARGET, input, XLEN: branch target.
REQ-010 SHALL provide port JMP, input, 1: unconditional jump.
REQ-011 SHALL provide port JMP_TARGET, input, XLEN: jump target.
REQ-012 SHALL provide port CALL, input, 1: jump is a call; qualifies JMP.
REQ-013 SHALL provide port RET, input, 1: return; target from RAS.
REQ-014 SHALL provide port TRAP, input, 1: trap redirect.
REQ-015 SHALL provide port TRAP_VEC, input, XLEN: trap handler address.
REQ-016 SHALL provide port PC, output, XLEN: current PC, registered.
REQ-017 SHALL provide port PC_PLUS, output, XLEN: PC+STEP, combinational, modulo 2^XLEN.
REQ-018 SHALL provide port MISALIGN, output, 1: registered; last loaded target was misaligned.
REQ-019 SHALL provide port RAS_EMPTY, output, 1: RAS holds no valid entry.
REQ-020 SHALL provide port RAS_FULL, output, 1: RAS holds RAS_DEPTH entries.
REQ-021 SHALL provide port RET_MISS, output, 1: combinational; RET selected while RAS empty.

Function
REQ-022 SHALL select next PC by priority: TRAP > BR_TAKEN > JMP > RET > sequential (PC_PLUS).
REQ-023 SHALL update PC on the rising CLK edge when PC_EN=1 or TRAP=1; TRAP overrides stall.
REQ-024 SHALL hold PC, RAS contents and RAS pointer when PC_EN=0 and TRAP=0, regardless of other inputs.
REQ-025 SHALL force the low log2(STEP) bits of any loaded target to zero, and set MISALIGN=1 for exactly the following cycle when the discarded bits were nonzero; otherwise MISALIGN=0.
REQ-026 SHALL wrap sequential PC from 2^XLEN-STEP to 0.
REQ-027 SHALL push PC_PLUS onto RAS when JMP=1 and CALL=1 are the selected source and the PC updates; CALL without JMP is ignored.
REQ-028 SHALL pop RAS top as next PC when RET is the selected source and RAS non-empty.
REQ-029 SHALL, on RET with RAS empty, assert RET_MISS, take PC_PLUS, and leave RAS unchanged.
REQ-030 SHALL, on push when full, overwrite the oldest entry (circular); count stays RAS_DEPTH.
REQ-031 SHALL leave RAS unchanged when a higher-priority source (TRAP, BR_TAKEN) masks CALL or RET.
REQ-032 SHALL give one-cycle latency: inputs sampled at edge N appear on PC after edge N.

Reset
REQ-033 SHALL, while RST_N=0, asynchronously force PC=RESET_VEC, MISALIGN=0, RAS count=0 (RAS_EMPTY=1, RAS_FULL=0).
REQ-034 SHALL leave RAS entry storage unreset; only the count and pointer are reset.
REQ-035 SHALL resume sequencing on the first rising edge after RST_N deasserts, with pending push/pop discarded.

Configuration
REQ-036 SHALL compile the RAS only when macro PC_SEQ_RAS_EN is defined.
REQ-037 SHALL, without PC_SEQ_RAS_EN, treat RET as sequential, CALL as plain JMP, tie RAS_EMPTY=1, RAS_FULL=0, RET_MISS=0.

Verification
REQ-038 SHALL check reset: RST_N=0 mid-cycle, RESET_VEC=32'h0000_1000 -> PC=0000_1000 immediately, RAS_EMPTY=1.
REQ-039 SHALL check sequencing and stall: PC_EN=1 three edges from 0 -> PC=0000_000C; PC_EN=0 with BR_TAKEN=1, BR_TARGET=DEAD_BEE0 -> PC holds 0000_000C.
REQ-040 SHALL check priority: TRAP=1, TRAP_VEC=8000_0000, BR_TAKEN=1, JMP=1, PC_EN=0 -> PC=8000_0000, RAS unchanged.
REQ-041 SHALL check call/return: CALL+JMP at PC=0000_0100 to 0000_2000; RET next -> PC=0000_0104, RAS_EMPTY=1; RET again -> RET_MISS=1, PC=0000_0108.
REQ-042 SHALL check RAS overflow: 5 calls with RAS_DEPTH=4 at PCs 10,20,30,40,50 -> RAS_FULL=1; 4 returns yield 54,44,34,24, then RAS_EMPTY=1.
REQ-043 SHALL check misalign and wrap: JMP_TARGET=0000_0203 -> PC=0000_0200, MISALIGN=1 one cycle; PC=FFFF_FFFC +STEP -> PC=0000_0000.

Source files
------------

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq
// Purpose  : Program-counter sequencer with priority redirect (trap, branch,
//            jump, return) and an optional return-address stack.
// Config   : define PC_SEQ_RAS_EN to build the return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            PC_EN,
  input  logic            BR_TAKEN,
  input  logic [XLEN-1:0] BR_TARGET,
  input  logic            JMP,
  input  logic [XLEN-1:0] JMP_TARGET,
  input  logic            CALL,
  input  logic            RET,
  input  logic            TRAP,
  input  logic [XLEN-1:0] TRAP_VEC,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS,
  output logic            MISALIGN,
  output logic            RAS_EMPTY,
  output logic            RAS_FULL,
  output logic            RET_MISS
);

  localparam logic [XLEN-1:0] c_STEP       = XLEN'(STEP);
  localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(STEP - 1);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_raw_target;
  logic            w_update;
  logic            w_load;
  logic            w_misaligned;
  logic            w_ret_sel;
  logic            w_pop;
  logic [XLEN-1:0] w_ras_top;

  assign w_pc_plus = r_pc + c_STEP;
  assign w_update  = PC_EN | TRAP;
  assign w_ret_sel = RET & ~TRAP & ~BR_TAKEN & ~JMP;

  // Explicit-target sources in priority order; RET and sequential handled below.
  always_comb begin
    w_raw_target = JMP_TARGET;
    w_load       = 1'b0;
    if (TRAP) begin
      w_raw_target = TRAP_VEC;
      w_load       = 1'b1;
    end else if (BR_TAKEN) begin
      w_raw_target = BR_TARGET;
      w_load       = 1'b1;
    end else if (JMP) begin
      w_raw_target = JMP_TARGET;
      w_load       = 1'b1;
    end
  end

  assign w_misaligned = |(w_raw_target & c_ALIGN_MASK);

  always_comb begin
    w_pc_next = w_pc_plus;
    if (w_load) begin
      w_pc_next = w_raw_target & ~c_ALIGN_MASK;
    end else if (w_pop) begin
      w_pc_next = w_ras_top;
    end
  end

  // MISALIGN reflects only the load performed on the immediately preceding edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      if (w_update) begin
        r_pc <= w_pc_next;
      end
      r_misalign <= w_update & w_load & w_misaligned;
    end
  end

  assign PC       = r_pc;
  assign PC_PLUS  = w_pc_plus;
  assign MISALIGN = r_misalign;

`ifdef PC_SEQ_RAS_EN
  localparam int                 c_PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(RAS_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;

  logic [XLEN-1:0]    r_ras_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ras_wptr;
  logic [c_PTR_W:0]   r_ras_cnt;
  logic [c_PTR_W-1:0] w_ras_rptr;
  logic               w_ras_empty;
  logic               w_ras_full;
  logic               w_push;

  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == c_DEPTH);
  assign w_push      = PC_EN & JMP & CALL & ~TRAP & ~BR_TAKEN;
  assign w_pop       = w_ret_sel & PC_EN & ~w_ras_empty;
  assign w_ras_rptr  = r_ras_wptr - c_PTR_ONE;
  assign w_ras_top   = r_ras_mem[w_ras_rptr];

  // Write pointer wraps naturally, so a push into a full stack overwrites the oldest entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ras_wptr <= '0;
      r_ras_cnt  <= '0;
    end else if (w_push) begin
      r_ras_wptr <= r_ras_wptr + c_PTR_ONE;
      if (!w_ras_full) begin
        r_ras_cnt <= r_ras_cnt + c_CNT_ONE;
      end
    end else if (w_pop) begin
      r_ras_wptr <= w_ras_rptr;
      r_ras_cnt  <= r_ras_cnt - c_CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_ras_mem[r_ras_wptr] <= w_pc_plus;
    end
  end

  assign RAS_EMPTY = w_ras_empty;
  assign RAS_FULL  = w_ras_full;
  assign RET_MISS  = w_ret_sel & w_ras_empty;
`else
  // Without the stack RET falls through to sequential and CALL acts as a plain JMP.
  assign w_pop     = 1'b0;
  assign w_ras_top = '0;
  assign RAS_EMPTY = 1'b1;
  assign RAS_FULL  = 1'b0;
  assign RET_MISS  = 1'b0;

  logic w_unused;
  assign w_unused = w_ret_sel ^ CALL ^ (RAS_DEPTH > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq
// Purpose  : Table-driven self-checking bench for pc_seq with expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

  localparam bit RAS_ON =
`ifdef PC_SEQ_RAS_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic        pc_en;
    logic        br;
    logic [31:0] br_t;
    logic        jmp;
    logic [31:0] jmp_t;
    logic        call;
    logic        ret;
    logic        trap;
    logic [31:0] trap_v;
    logic [31:0] e_pc;
    logic        e_mis;
    logic        e_empty;
    logic        e_full;
    logic        e_miss;
  } vec_t;

  logic        CLK;
  logic        RST_N;
  logic        PC_EN;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        JMP;
  logic [31:0] JMP_TARGET;
  logic        CALL;
  logic        RET;
  logic        TRAP;
  logic [31:0] TRAP_VEC;
  logic [31:0] PC;
  logic [31:0] PC_PLUS;
  logic        MISALIGN;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RET_MISS;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];
  vec_t sb[$];

  pc_seq #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_1000),
    .STEP      (4),
    .RAS_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PC_EN      (PC_EN),
    .BR_TAKEN   (BR_TAKEN),
    .BR_TARGET  (BR_TARGET),
    .JMP        (JMP),
    .JMP_TARGET (JMP_TARGET),
    .CALL       (CALL),
    .RET        (RET),
    .TRAP       (TRAP),
    .TRAP_VEC   (TRAP_VEC),
    .PC         (PC),
    .PC_PLUS    (PC_PLUS),
    .MISALIGN   (MISALIGN),
    .RAS_EMPTY  (RAS_EMPTY),
    .RAS_FULL   (RAS_FULL),
    .RET_MISS   (RET_MISS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(
    input logic en, input logic br, input logic [31:0] bt,
    input logic jmp, input logic [31:0] jt, input logic call, input logic ret,
    input logic trap, input logic [31:0] tv,
    input logic [31:0] epc, input logic emis, input logic eempty,
    input logic efull, input logic emiss);
    vec_t v;
    v.pc_en = en;   v.br = br;     v.br_t = bt;
    v.jmp = jmp;    v.jmp_t = jt;  v.call = call; v.ret = ret;
    v.trap = trap;  v.trap_v = tv;
    v.e_pc = epc;   v.e_mis = emis; v.e_empty = eempty;
    v.e_full = efull; v.e_miss = emiss;
    return v;
  endfunction

  task automatic idle_inputs();
    PC_EN = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0; JMP = 1'b0; JMP_TARGET = '0;
    CALL = 1'b0; RET = 1'b0; TRAP = 1'b0; TRAP_VEC = '0;
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    PC_EN = v.pc_en; BR_TAKEN = v.br; BR_TARGET = v.br_t;
    JMP = v.jmp; JMP_TARGET = v.jmp_t; CALL = v.call; RET = v.ret;
    TRAP = v.trap; TRAP_VEC = v.trap_v;
    #1;
    chk({tag, ".ret_miss"}, {31'b0, RET_MISS}, {31'b0, v.e_miss});
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, PC, e.e_pc);
    chk({tag, ".pc_plus"}, PC_PLUS, e.e_pc + 32'd4);
    chk({tag, ".misalign"}, {31'b0, MISALIGN}, {31'b0, e.e_mis});
    chk({tag, ".ras_empty"}, {31'b0, RAS_EMPTY}, {31'b0, e.e_empty});
    chk({tag, ".ras_full"}, {31'b0, RAS_FULL}, {31'b0, e.e_full});
  endtask

  initial begin
    logic nr;
    nr = ~RAS_ON;
    idle_inputs();
    RST_N = 1'b0;

    //          en br bt            jmp jt            call ret trap tv          exp_pc                     mis empty full miss
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_1004,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h0,      0,0,0,32'h0,         32'h0000_0000,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0004,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0008,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_000C,             0,1,0,0));
    vecs.push_back(mk(0,1,32'hDEAD_BEE0,0,32'h0,      0,0,0,32'h0,         32'h0000_000C,             0,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        1,32'h500,    1,0,0,32'h0,         32'h0000_000C,             0,1,0,0));
    vecs.push_back(mk(0,1,32'hDEAD_BEE0,1,32'h500,    1,0,1,32'h8000_0000, 32'h8000_0000,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h100,    0,0,0,32'h0,         32'h0000_0100,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h2000,   1,0,0,32'h0,         32'h0000_2000,             0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h104 : 32'h2004, 0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h108 : 32'h2008, 0,1,0,RAS_ON));
    vecs.push_back(mk(1,0,32'h0,        1,32'h10,     0,0,0,32'h0,         32'h0000_0010,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h20,     1,0,0,32'h0,         32'h0000_0020,             0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h30,     1,0,0,32'h0,         32'h0000_0030,             0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h40,     1,0,0,32'h0,         32'h0000_0040,             0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h50,     1,0,0,32'h0,         32'h0000_0050,             0,nr,RAS_ON,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h60,     1,0,0,32'h0,         32'h0000_0060,             0,nr,RAS_ON,0));
    vecs.push_back(mk(1,1,32'h70,       0,32'h0,      0,1,0,32'h0,         32'h0000_0070,             0,nr,RAS_ON,0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h90,     1,0,1,32'h80,        32'h0000_0080,             0,nr,RAS_ON,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h54 : 32'h84,  0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h44 : 32'h88,  0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h34 : 32'h8C,  0,nr,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h24 : 32'h90,  0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,1,0,32'h0,         RAS_ON ? 32'h28 : 32'h94,  0,1,0,RAS_ON));
    vecs.push_back(mk(1,0,32'h0,        1,32'h203,    0,0,0,32'h0,         32'h0000_0200,             1,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0204,             0,1,0,0));
    vecs.push_back(mk(1,1,32'h301,      0,32'h0,      0,0,0,32'h0,         32'h0000_0300,             1,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0300,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,1,32'hFFFF_FFFE, 32'hFFFF_FFFC,             1,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0000,             0,1,0,0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,      0,0,0,32'h0,         32'h0000_0004,             0,1,0,0));

    #12;
    chk("rst.pc", PC, 32'h0000_1000);
    chk("rst.misalign", {31'b0, MISALIGN}, 32'h0);
    chk("rst.ras_empty", {31'b0, RAS_EMPTY}, 32'h1);
    chk("rst.ras_full", {31'b0, RAS_FULL}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Misaligned call, then reset mid-cycle: PC returns immediately and the stack empties.
    step(mk(1,0,32'h0,1,32'h403,1,0,0,32'h0, 32'h0000_0400,1,nr,0,0), "pre_rst");
    #2;
    idle_inputs();
    RST_N = 1'b0;
    #1;
    chk("midrst.pc", PC, 32'h0000_1000);
    chk("midrst.misalign", {31'b0, MISALIGN}, 32'h0);
    chk("midrst.ras_empty", {31'b0, RAS_EMPTY}, 32'h1);
    chk("midrst.ras_full", {31'b0, RAS_FULL}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    // The pre-reset push is gone, so this RET misses and falls through.
    step(mk(1,0,32'h0,0,32'h0,0,1,0,32'h0, 32'h0000_1004,0,1,0,RAS_ON), "post_rst");

    chk("sb_drain", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
